ioctl_upload_reader: RTL and testbench

Upload-side counterpart of the ROM download path: it serves `data_io` upload requests (NVRAM/hiscore save, `ioctl_upload` with a matching index) by reading bytes from a 16-bit memory port and presenting them on `ioctl_din`. It sits in the MiST top level between `data_io` and a toggle-handshake memory port, the same style as the SDRAM `portN_req`/`portN_ack` ports. While an upload is in progress it holds the core paused, so the memory contents are stable for the whole transfer.

---
 rtl/mist_io_pkg.sv | 18 +
 rtl/toggle_req_port.sv | 47 ++++
 rtl/ioctl_upload_reader.sv | 165 ++++++++++++++++
 tb/tb_ioctl_upload_reader.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mist_io_pkg.sv
// Shared definitions for the MiST data_io helper blocks (upload/download sides).
package mist_io_pkg;

  localparam logic [7:0] NVRAM_INDEX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_FETCH,
    ST_READY,
    ST_DRAIN
  } upload_state_e;

  function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/toggle_req_port.sv
// Toggle-handshake memory request port: owns mem_req, the registered mem_ack
// compare and the outstanding flag so it can be shared with the download path.
module toggle_req_port #(
  parameter int WAW = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [WAW-1:0] start_addr,
  input  logic           mem_ack,
  output logic           mem_req,
  output logic [WAW-1:0] mem_addr,
  output logic           outstanding
);

  logic           req_q, req_d;
  logic           ack_q, ack_d;
  logic [WAW-1:0] addr_q, addr_d;

  // A start while a request is still in flight is dropped, never re-toggled.
  always_comb begin
    req_d  = req_q;
    addr_d = addr_q;
    ack_d  = mem_ack;
    if (start && !outstanding) begin
      req_d  = ~req_q;
      addr_d = start_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q  <= 1'b0;
      ack_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      req_q  <= req_d;
      ack_q  <= ack_d;
      addr_q <= addr_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign outstanding = req_q ^ ack_q;

endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves data_io uploads for one ioctl_index by reading bytes from a 16-bit
// toggle-handshake memory port, holding the core paused for the whole transfer.
module ioctl_upload_reader
  import mist_io_pkg::*;
#(
  parameter logic [7:0] INDEX  = NVRAM_INDEX,
  parameter int         AW     = 16,
  parameter int         SETTLE = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic [AW-1:0] ioctl_addr,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-2:0] mem_addr,
  input  logic [15:0]   mem_q,
  output logic          core_hold,
  output logic          busy,
  output logic          overrun
);

  upload_state_e state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    din_q, din_d;
  logic          hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          overrun_q, overrun_d;
  logic          buf_ok_q, buf_ok_d;
  logic [15:0]   word_buf_q, word_buf_d;
  logic [AW-2:0] tag_q, tag_d;

  logic          act;
  logic          drop;
  logic          port_start;
  logic          outstanding;
  logic [AW-2:0] rd_word;

  assign act     = ioctl_upload && (ioctl_index == INDEX);
  assign rd_word = ioctl_addr[AW-1:1];

  toggle_req_port #(
    .WAW(AW - 1)
  ) u_port (
    .clk        (clk_sys),
    .reset      (reset),
    .start      (port_start),
    .start_addr (rd_word),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .outstanding(outstanding)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    din_d      = din_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    buf_ok_d   = buf_ok_q;
    word_buf_d = word_buf_q;
    tag_d      = tag_q;
    port_start = 1'b0;
    drop       = 1'b0;

    if (ioctl_rd && (state_q == ST_HOLD || state_q == ST_FETCH)) overrun_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (act) begin
          state_d   = ST_HOLD;
          hold_d    = 1'b1;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
          cnt_d     = 16'(SETTLE - 1);
        end
      end
      ST_HOLD: begin
        if (!act) begin
          drop = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!outstanding) begin
          port_start = 1'b1;
          state_d    = ST_FETCH;
        end
      end
      // A read that arrived mid-fetch has already moved ioctl_addr, so a
      // word mismatch here chains straight into the next fetch.
      ST_FETCH: begin
        if (!act) begin
          drop = 1'b1;
        end else if (!outstanding) begin
          word_buf_d = mem_q;
          tag_d      = mem_addr;
          buf_ok_d   = 1'b1;
          if (rd_word != mem_addr) begin
            port_start = 1'b1;
          end else begin
            state_d = ST_READY;
            din_d   = pick_byte(mem_q, ioctl_addr[0]);
          end
        end
      end
      ST_READY: begin
        if (!act) begin
          drop = 1'b1;
        end else if (ioctl_rd && !(buf_ok_q && rd_word == tag_q)) begin
          port_start = 1'b1;
          state_d    = ST_FETCH;
        end else begin
          din_d = pick_byte(word_buf_q, ioctl_addr[0]);
        end
      end
      ST_DRAIN: drop = 1'b1;
      default:  state_d = ST_IDLE;
    endcase

    if (drop) begin
      if (outstanding) begin
        state_d = ST_DRAIN;
      end else begin
        state_d  = ST_IDLE;
        hold_d   = 1'b0;
        busy_d   = 1'b0;
        buf_ok_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      din_q      <= '0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      buf_ok_q   <= 1'b0;
      word_buf_q <= '0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      buf_ok_q   <= buf_ok_d;
      word_buf_q <= word_buf_d;
      tag_q      <= tag_d;
    end
  end

  assign ioctl_din = din_q;
  assign core_hold = hold_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed/randomized bench for ioctl_upload_reader with a behavioural
// toggle-handshake memory and a byte-level reference model.
module tb_ioctl_upload_reader;

  localparam int         AW     = 8;
  localparam int         SETTLE = 4;
  localparam logic [7:0] IDX    = 8'hFF;

  logic          clk_sys;
  logic          reset;
  logic          ioctl_upload;
  logic [7:0]    ioctl_index;
  logic [AW-1:0] ioctl_addr;
  logic          ioctl_rd;
  logic [7:0]    ioctl_din;
  logic          mem_req;
  logic          mem_ack = 1'b0;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_q = 16'h0000;
  logic          core_hold;
  logic          busy;
  logic          overrun;

  logic [15:0] memWords [0:(1 << (AW - 1)) - 1];
  int          memLat;
  int          latCnt = 0;
  int          toggleCount = 0;
  int          doubleOut = 0;
  logic        prevReq = 1'b0;
  int          fetchLog[$];
  int          checks;
  int          errors;

  ioctl_upload_reader #(
    .INDEX (IDX),
    .AW    (AW),
    .SETTLE(SETTLE)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_addr  (ioctl_addr),
    .ioctl_rd    (ioctl_rd),
    .ioctl_din   (ioctl_din),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .mem_addr    (mem_addr),
    .mem_q       (mem_q),
    .core_hold   (core_hold),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Memory model: answers each request toggle after memLat cycles, logs every
  // fetched word and counts toggles issued while a request was still open.
  always @(negedge clk_sys) begin
    if (reset) begin
      mem_ack = 1'b0;
      latCnt  = 0;
      prevReq = 1'b0;
    end else begin
      if (mem_req !== prevReq) begin
        toggleCount++;
        fetchLog.push_back(int'(mem_addr));
        if (mem_ack !== prevReq) doubleOut++;
        prevReq = mem_req;
      end
      if (mem_req !== mem_ack) begin
        latCnt++;
        if (latCnt >= memLat) begin
          mem_ack = mem_req;
          mem_q   = memWords[mem_addr];
          latCnt  = 0;
        end
      end
    end
  end

  function automatic logic [7:0] byteOf(input int a);
    int          b;
    logic [15:0] w;
    b = a % (1 << AW);
    w = memWords[b / 2];
    return (b % 2 != 0) ? w[15:8] : w[7:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic upload, input logic [7:0] index);
    ioctl_upload = upload;
    ioctl_index  = index;
  endtask

  task automatic readByte(input logic [AW-1:0] addr);
    ioctl_addr = addr;
    ioctl_rd   = 1'b1;
    tick(1);
    ioctl_rd   = 1'b0;
  endtask

  initial begin
    int t0;
    int curAddr;
    int nxt;
    int holdBad;
    int fell;
    int ackSeenAt;
    int fellAt;

    checks       = 0;
    errors       = 0;
    memLat       = 5;
    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'h00;
    ioctl_addr   = '0;
    ioctl_rd     = 1'b0;
    for (int i = 0; i < (1 << (AW - 1)); i++) memWords[i] = 16'($urandom);
    memWords[0] = 16'hBEEF;

    tick(3);
    reset = 1'b0;
    tick(1);
    checkOutput("reset_din", 32'(ioctl_din), 32'h0);
    checkOutput("reset_req", 32'(mem_req), 32'h0);
    checkOutput("reset_addr", 32'(mem_addr), 32'h0);
    checkOutput("reset_hold", 32'(core_hold), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_overrun", 32'(overrun), 32'h0);

    // First upload: settle timing and first byte
    applyStimulus(1'b1, IDX);
    tick(1);
    checkOutput("hold_rise", 32'(core_hold), 32'h1);
    checkOutput("busy_rise", 32'(busy), 32'h1);
    tick(SETTLE - 1);
    checkOutput("req_before_settle", 32'(mem_req), 32'h0);
    tick(1);
    checkOutput("req_after_settle", 32'(mem_req), 32'h1);
    checkOutput("first_addr", 32'(mem_addr), 32'h0);
    for (int i = 0; i < 20 && mem_ack !== mem_req; i++) tick(1);
    checkOutput("first_ack_seen", 32'(mem_ack === mem_req), 32'h1);
    tick(1);
    checkOutput("first_byte", 32'(ioctl_din), 32'hEF);

    // Same-word hit then next-word miss
    t0 = toggleCount;
    readByte(8'd1);
    checkOutput("hit_byte", 32'(ioctl_din), 32'hBE);
    tick(memLat + 4);
    checkOutput("hit_no_fetch", toggleCount - t0, 0);
    readByte(8'd2);
    tick(memLat + 6);
    checkOutput("miss_byte", 32'(ioctl_din), 32'(byteOf(2)));
    checkOutput("miss_one_fetch", toggleCount - t0, 1);
    checkOutput("miss_word", fetchLog[$], 1);

    curAddr = 2;
    for (int i = 0; i < 6; i++) begin
      nxt = (curAddr + int'($urandom_range(1, 3))) % (1 << AW);
      t0  = toggleCount;
      readByte(AW'(nxt));
      tick(memLat + 6);
      checkOutput("rand_byte", 32'(ioctl_din), 32'(byteOf(nxt)));
      checkOutput("rand_fetches", toggleCount - t0, (nxt / 2 != curAddr / 2) ? 1 : 0);
      curAddr = nxt;
    end

    // Address wrap from the top byte back to zero
    readByte(8'hFF);
    tick(memLat + 6);
    checkOutput("wrap_top_byte", 32'(ioctl_din), 32'(byteOf(255)));
    readByte(8'h00);
    tick(memLat + 6);
    checkOutput("wrap_zero_byte", 32'(ioctl_din), 32'(byteOf(0)));
    checkOutput("wrap_word", fetchLog[$], 0);
    checkOutput("no_overrun", 32'(overrun), 32'h0);

    applyStimulus(1'b0, IDX);
    tick(1);
    checkOutput("drop_idle_hold", 32'(core_hold), 32'h0);
    checkOutput("drop_idle_busy", 32'(busy), 32'h0);

    // Foreign index must be ignored
    t0 = toggleCount;
    applyStimulus(1'b1, 8'h00);
    tick(SETTLE + 12);
    checkOutput("foreign_hold", 32'(core_hold), 32'h0);
    checkOutput("foreign_busy", 32'(busy), 32'h0);
    checkOutput("foreign_fetches", toggleCount - t0, 0);
    applyStimulus(1'b0, 8'h00);
    tick(2);

    // Overrun: read while the first fetch is still open
    memLat     = 8;
    ioctl_addr = 8'h10;
    t0         = toggleCount;
    applyStimulus(1'b1, IDX);
    for (int i = 0; i < 20 && mem_req === mem_ack; i++) tick(1);
    checkOutput("ovr_fetch_started", 32'(mem_req !== mem_ack), 32'h1);
    tick(2);
    readByte(8'h12);
    tick(30);
    checkOutput("ovr_flag", 32'(overrun), 32'h1);
    checkOutput("ovr_fetches", toggleCount - t0, 2);
    checkOutput("ovr_first_word", fetchLog[$-1], 8);
    checkOutput("ovr_second_word", fetchLog[$], 9);
    checkOutput("ovr_byte", 32'(ioctl_din), 32'(byteOf(8'h12)));
    applyStimulus(1'b0, IDX);
    tick(2);
    checkOutput("ovr_sticky", 32'(overrun), 32'h1);
    ioctl_addr = 8'h00;
    applyStimulus(1'b1, IDX);
    tick(1);
    checkOutput("ovr_cleared", 32'(overrun), 32'h0);
    tick(20);
    checkOutput("reup_byte", 32'(ioctl_din), 32'(byteOf(0)));

    // Drop the upload while a fetch is outstanding
    readByte(8'h20);
    tick(2);
    applyStimulus(1'b0, IDX);
    holdBad   = 0;
    fell      = 0;
    ackSeenAt = -1;
    fellAt    = -1;
    for (int i = 0; i < 40 && fell == 0; i++) begin
      tick(1);
      if (mem_ack !== mem_req && core_hold !== 1'b1) holdBad++;
      if (ackSeenAt < 0 && mem_ack === mem_req) ackSeenAt = i;
      if (core_hold === 1'b0) begin
        fell   = 1;
        fellAt = i;
      end
    end
    checkOutput("drain_hold_high", holdBad, 0);
    checkOutput("drain_fell", fell, 1);
    checkOutput("drain_fall_delay", fellAt - ackSeenAt, 1);
    checkOutput("drain_ack_match", 32'(mem_ack === mem_req), 32'h1);
    checkOutput("drain_busy", 32'(busy), 32'h0);

    // Reset mid-READY, then a fresh upload must refetch word 0
    memLat     = 5;
    ioctl_addr = 8'h06;
    applyStimulus(1'b1, IDX);
    tick(1);
    checkOutput("restart_hold", 32'(core_hold), 32'h1);
    tick(20);
    checkOutput("pre_reset_byte", 32'(ioctl_din), 32'(byteOf(6)));
    reset = 1'b1;
    tick(1);
    checkOutput("midreset_din", 32'(ioctl_din), 32'h0);
    checkOutput("midreset_req", 32'(mem_req), 32'h0);
    checkOutput("midreset_addr", 32'(mem_addr), 32'h0);
    checkOutput("midreset_hold", 32'(core_hold), 32'h0);
    checkOutput("midreset_busy", 32'(busy), 32'h0);
    checkOutput("midreset_overrun", 32'(overrun), 32'h0);
    memWords[0] = 16'h1234;
    applyStimulus(1'b0, IDX);
    ioctl_addr = 8'h00;
    tick(2);
    reset = 1'b0;
    tick(1);
    t0 = toggleCount;
    applyStimulus(1'b1, IDX);
    tick(20);
    checkOutput("post_reset_fetches", toggleCount - t0, 1);
    checkOutput("post_reset_word", fetchLog[$], 0);
    checkOutput("post_reset_lo", 32'(ioctl_din), 32'h34);
    readByte(8'd1);
    checkOutput("post_reset_hi", 32'(ioctl_din), 32'h12);
    tick(memLat + 4);
    checkOutput("post_reset_hit", toggleCount - t0, 1);
    applyStimulus(1'b0, IDX);
    tick(3);
    checkOutput("never_double_outstanding", doubleOut, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
